// File: rtl/brk_arbiter_pkg.sv
// Shared encodings and widths for the data-break arbiter; imported by brk_arbiter.
// Optional round-robin priority is enabled with the BRK_ROUND_ROBIN_EN macro.
package brk_arbiter_pkg;

  localparam int BRK_AW = 15;
  localparam int BRK_DW = 12;

  typedef enum logic [2:0] {
    BRK_IDLE  = 3'd0,
    BRK_GRANT = 3'd1,
    BRK_WAITB = 3'd2,
    BRK_INB   = 3'd3,
    BRK_DONE  = 3'd4
  } brk_state_t;

endpackage

// File: rtl/brk_prio_sel.sv
// Combinational priority picker: first set req bit at or after start, wrapping modulo NREQ.
module brk_prio_sel #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IW'((int'(start) + k) % NREQ);
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/brk_arbiter.sv
// Shares the CPU data-break channel between NREQ requesters and sequences one break per grant.
// Define BRK_ROUND_ROBIN_EN for rotating priority; otherwise index 0 always has highest priority.
module brk_arbiter
  import brk_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [NREQ-1:0]        req,
  input  logic [BRK_AW*NREQ-1:0] req_addr,
  input  logic [NREQ-1:0]        req_to_mem,
  input  logic [BRK_DW*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]        ack,
  output logic [NREQ-1:0]        err,
  output logic [BRK_DW-1:0]      rdata,
  output logic                   data_break,
  output logic                   to_disk,
  output logic [BRK_AW-1:0]      dmaAddr,
  output logic [BRK_DW-1:0]      disk2mem,
  input  logic [BRK_DW-1:0]      mem2disk,
  input  logic                   break_in_prog,
  output logic                   busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  brk_state_t      state, state_nxt;
  logic [TW-1:0]   tcnt;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   start;
  logic [NREQ-1:0] sel_grant;
  logic [IW-1:0]   sel_idx;
  logic            sel_any;
  logic [BRK_AW-1:0] sel_addr;
  logic [BRK_DW-1:0] sel_wdata;
  logic            sel_to_mem;
  logic            timeout_hit, done_evt, err_evt;

  brk_prio_sel #(.NREQ(NREQ), .IW(IW)) u_prio_sel (
    .req   (req),
    .start (start),
    .grant (sel_grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  always_comb begin
    sel_addr   = '0;
    sel_wdata  = '0;
    sel_to_mem = 1'b0;
    win_oh     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_grant[i]) begin
        sel_addr   = req_addr[i*BRK_AW +: BRK_AW];
        sel_wdata  = req_wdata[i*BRK_DW +: BRK_DW];
        sel_to_mem = req_to_mem[i];
      end
      win_oh[i] = (win_idx == IW'(i));
    end
  end

  // A started memory cycle must finish, so break_in_prog outranks clear and timeout in WAITB.
  assign timeout_hit = (tcnt == TW'(TIMEOUT - 1));
  assign err_evt     = (state == BRK_WAITB) && !break_in_prog && !clear && timeout_hit;
  assign done_evt    = (state == BRK_INB) && !break_in_prog;
  assign busy        = (state != BRK_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      BRK_IDLE:  if (sel_any && !clear) state_nxt = BRK_GRANT;
      BRK_GRANT: state_nxt = BRK_WAITB;
      BRK_WAITB: begin
        if (break_in_prog)    state_nxt = BRK_INB;
        else if (clear)       state_nxt = BRK_IDLE;
        else if (timeout_hit) state_nxt = BRK_IDLE;
      end
      BRK_INB:   if (!break_in_prog) state_nxt = BRK_DONE;
      BRK_DONE:  state_nxt = BRK_IDLE;
      default:   state_nxt = BRK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= BRK_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_break <= 1'b0;
      to_disk    <= 1'b0;
      dmaAddr    <= '0;
      disk2mem   <= '0;
      rdata      <= '0;
      ack        <= '0;
      err        <= '0;
      tcnt       <= '0;
      win_idx    <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      case (state)
        BRK_IDLE: begin
          if (state_nxt == BRK_GRANT) begin
            dmaAddr  <= sel_addr;
            disk2mem <= sel_wdata;
            to_disk  <= ~sel_to_mem;
            win_idx  <= sel_idx;
          end
        end
        BRK_GRANT: begin
          data_break <= 1'b1;
          tcnt       <= '0;
        end
        BRK_WAITB: begin
          tcnt <= tcnt + TW'(1);
          if (state_nxt != BRK_WAITB) data_break <= 1'b0;
          if (err_evt) err <= win_oh;
        end
        BRK_INB: begin
          if (break_in_prog && to_disk) rdata <= mem2disk;
          if (done_evt) ack <= win_oh;
        end
        default: ;
      endcase
    end
  end

`ifdef BRK_ROUND_ROBIN_EN
  logic [IW-1:0] ptr;

  always_ff @(posedge clk) begin
    if (!reset)                   ptr <= '0;
    else if (done_evt || err_evt) ptr <= IW'((int'(win_idx) + 1) % NREQ);
  end

  assign start = ptr;
`else
  assign start = '0;
`endif

endmodule

// File: tb/tb_brk_arbiter.sv
// Directed bench for brk_arbiter: write, read, contention, timeout, clear and reset cases.
module tb_brk_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 20;

  logic             clk;
  logic             reset;
  logic             clear;
  logic [NREQ-1:0]  req;
  logic [15*NREQ-1:0] req_addr;
  logic [NREQ-1:0]  req_to_mem;
  logic [12*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]  ack;
  logic [NREQ-1:0]  err;
  logic [11:0]      rdata;
  logic             data_break;
  logic             to_disk;
  logic [14:0]      dmaAddr;
  logic [11:0]      disk2mem;
  logic [11:0]      mem2disk;
  logic             break_in_prog;
  logic             busy;

  int total = 0;
  int bad   = 0;
  logic [13:0] exp_q[$];

  brk_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .req           (req),
    .req_addr      (req_addr),
    .req_to_mem    (req_to_mem),
    .req_wdata     (req_wdata),
    .ack           (ack),
    .err           (err),
    .rdata         (rdata),
    .data_break    (data_break),
    .to_disk       (to_disk),
    .dmaAddr       (dmaAddr),
    .disk2mem      (disk2mem),
    .mem2disk      (mem2disk),
    .break_in_prog (break_in_prog),
    .busy          (busy)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] mem_word(input logic [14:0] a);
    return a[11:0] ^ 12'o5555;
  endfunction

  task automatic set_req(input int i, input logic [14:0] a, input logic tm, input logic [11:0] w);
    req_addr[i*15 +: 15]  = a;
    req_to_mem[i]         = tm;
    req_wdata[i*12 +: 12] = w;
  endtask

  task automatic wait_db(input string tag);
    int n = 0;
    while (data_break !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, data_break, 1);
  endtask

  // memory side of one break: answers from the model memory at the granted address
  task automatic serve(output logic [1:0] a, output logic [11:0] d);
    int n = 0;
    wait_db("srv_db");
    mem2disk      = mem_word(dmaAddr);
    break_in_prog = 1'b1;
    tick();
    tick();
    break_in_prog = 1'b0;
    while (ack == '0 && n < 5) begin
      tick();
      n++;
    end
    a = ack;
    d = rdata;
  endtask

  task automatic sb_check(input string tag, input logic [1:0] a, input logic [11:0] d);
    logic [13:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_q"}, exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_ack"}, a, e[13:12]);
      chk({tag, "_rd"}, d, e[11:0]);
    end
  endtask

  initial begin
    logic [1:0]  a;
    logic [11:0] d;
    logic [1:0]  seen;
    logic        last_db;
    int          n;

    reset = 1'b0; clear = 1'b0; req = '0; req_addr = '0; req_to_mem = '0;
    req_wdata = '0; mem2disk = '0; break_in_prog = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_db", data_break, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", dmaAddr, 0);
    chk("rst_wdata", disk2mem, 0);
    chk("rst_dir", to_disk, 0);
    reset = 1'b1;
    tick();

    // single write from requester 0
    set_req(0, 15'o10200, 1'b1, 12'o1234);
    req = 2'b01;
    tick();
    chk("w_db_early", data_break, 0);
    chk("w_busy", busy, 1);
    chk("w_addr", dmaAddr, 15'o10200);
    chk("w_wdata", disk2mem, 12'o1234);
    chk("w_dir", to_disk, 0);
    tick();
    chk("w_db", data_break, 1);
    break_in_prog = 1'b1;
    tick();
    chk("w_db_drop", data_break, 0);
    tick();
    tick();
    chk("w_no_ack", ack, 0);
    break_in_prog = 1'b0;
    tick();
    chk("w_ack", ack, 2'b01);
    chk("w_rdata", rdata, 0);
    req = '0;
    tick();
    chk("w_ack_pulse", ack, 0);
    chk("w_idle", busy, 0);

    // single read from requester 1
    set_req(1, 15'o00017, 1'b0, 12'o0);
    req = 2'b10;
    tick();
    tick();
    chk("r_db", data_break, 1);
    chk("r_dir", to_disk, 1);
    chk("r_addr", dmaAddr, 15'o00017);
    mem2disk = 12'o7070;
    break_in_prog = 1'b1;
    repeat (3) tick();
    break_in_prog = 1'b0;
    mem2disk = '0;
    tick();
    chk("r_ack", ack, 2'b10);
    chk("r_data", rdata, 12'o7070);
    req = '0;
    tick();

    // contention: both raised together, each drops after its own ack
    set_req(0, 15'o00100, 1'b0, 12'o0);
    set_req(1, 15'o00200, 1'b0, 12'o0);
    exp_q.push_back({2'b01, mem_word(15'o00100)});
    exp_q.push_back({2'b10, mem_word(15'o00200)});
    req = 2'b11;
    for (int s = 0; s < 2; s++) begin
      serve(a, d);
      sb_check("ca", a, d);
      req = req & ~a;
    end
    tick();

    // contention: both held across four services
    for (int s = 0; s < 4; s++) begin
`ifdef BRK_ROUND_ROBIN_EN
      if (s % 2 == 0) exp_q.push_back({2'b01, mem_word(15'o00100)});
      else            exp_q.push_back({2'b10, mem_word(15'o00200)});
`else
      exp_q.push_back({2'b01, mem_word(15'o00100)});
`endif
    end
    req = 2'b11;
    for (int s = 0; s < 4; s++) begin
      serve(a, d);
      sb_check("cb", a, d);
    end
    req = '0;
    tick();
    tick();

    // timeout with break_in_prog never arriving
    set_req(0, 15'o04000, 1'b1, 12'o0777);
    req = 2'b01;
    n = 0; seen = '0; last_db = 1'b0;
    while (err == '0 && n < TIMEOUT + 10) begin
      last_db = data_break;
      tick();
      n++;
      seen = seen | ack;
    end
    chk("to_cycles", n, TIMEOUT + 2);
    chk("to_err", err, 2'b01);
    chk("to_db_off", data_break, 0);
    chk("to_db_before", last_db, 1);
    chk("to_no_ack", seen, 0);
    req = '0;
    tick();
    chk("to_err_pulse", err, 0);

    // clear while waiting for the break
    set_req(0, 15'o00500, 1'b1, 12'o0055);
    req = 2'b01;
    wait_db("cw_db");
    clear = 1'b1;
    tick();
    chk("cw_db_off", data_break, 0);
    chk("cw_idle", busy, 0);
    seen = ack | err;
    req = '0;
    clear = 1'b0;
    repeat (3) begin
      tick();
      seen = seen | ack | err;
    end
    chk("cw_silent", seen, 0);

    // clear during the break cycle is ignored
    set_req(1, 15'o00033, 1'b0, 12'o0);
    req = 2'b10;
    wait_db("ci_db");
    break_in_prog = 1'b1;
    mem2disk = 12'o7777;
    tick();
    clear = 1'b1;
    mem2disk = 12'o5252;
    tick();
    break_in_prog = 1'b0;
    tick();
    chk("ci_ack", ack, 2'b10);
    chk("ci_rdata", rdata, 12'o5252);
    clear = 1'b0;
    req = '0;
    tick();

    // reset in the middle of a break cycle
    set_req(0, 15'o01234, 1'b1, 12'o4321);
    req = 2'b01;
    wait_db("ri_db");
    break_in_prog = 1'b1;
    tick();
    chk("ri_busy", busy, 1);
    reset = 1'b0;
    tick();
    chk("ri_busy0", busy, 0);
    chk("ri_db0", data_break, 0);
    chk("ri_dir0", to_disk, 0);
    chk("ri_addr0", dmaAddr, 0);
    chk("ri_wdata0", disk2mem, 0);
    chk("ri_rdata0", rdata, 0);
    chk("ri_ackerr0", {ack, err}, 0);
    req = '0;
    reset = 1'b1;
    seen = '0;
    tick();
    seen = seen | ack;
    tick();
    seen = seen | ack;
    break_in_prog = 1'b0;
    repeat (4) begin
      tick();
      seen = seen | ack;
    end
    chk("ri_no_ack", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
